// File: rtl/system_0_sysid_pkg.sv
// Shared types and helpers for the system-ID checker: FSM state encoding,
// slave word addresses and the wait-counter width function.
package system_0_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_FIN    = 3'd5
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // ceil(log2(n+1)), never below 1
  function automatic int unsigned sysid_cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/system_0_sysid_rd_timer.sv
// Loadable down-counter shared by the read-timeout and read-latency waits;
// hit_o flags the last counted cycle (terminal count).
module system_0_sysid_rd_timer
  import system_0_sysid_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         hit_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = limit_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The owner qualifies this with its own enable condition.
  assign hit_o = (count_q == W'(1));

endmodule

// File: rtl/system_0_sysid_checker.sv
// Avalon-MM read master that fetches system ID and build timestamp from the
// sysid slave after reset or on request and flags mismatches / timeouts.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start or the post-reset automatic launch
// REQ_ID    | av_read at word 0, held until waitrequest drops or timeout
// LAT_ID    | ID read accepted, waiting READ_LATENCY cycles for readdata
// REQ_TS    | av_read at word 1, held until waitrequest drops or timeout
// LAT_TS    | TS read accepted, waiting READ_LATENCY cycles for readdata
// FIN       | check over; done pulses on the following cycle
module system_0_sysid_checker
  import system_0_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1563397180,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned TO_W  = sysid_cnt_width(TIMEOUT_CYCLES);
  // Latency count goes up to 3, so keep at least two bits.
  localparam int unsigned CNT_W = (TO_W < 2) ? 2 : TO_W;
  localparam logic [CNT_W-1:0] LIM_TO  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIM_LAT = CNT_W'(READ_LATENCY);
  localparam bit HAS_LAT = (READ_LATENCY != 0);

  sysid_chk_state_t state_q, state_d;

  logic        auto_q;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic             in_req;
  logic             in_lat;
  logic             tmr_en;
  logic             tmr_hit;
  logic             tmr_clear;
  logic [CNT_W-1:0] tmr_limit;
  logic             launch;
  logic             cap_id;
  logic             cap_ts;
  logic             to_hit;

  assign in_req = (state_q == ST_REQ_ID) || (state_q == ST_REQ_TS);
  assign in_lat = (state_q == ST_LAT_ID) || (state_q == ST_LAT_TS);
  assign tmr_en = (in_req && av_waitrequest) || in_lat;

  // Reload on every state change so each read gets a fresh window.
  assign tmr_clear = (state_d != state_q);
  assign tmr_limit = ((state_d == ST_LAT_ID) || (state_d == ST_LAT_TS)) ? LIM_LAT : LIM_TO;

  system_0_sysid_rd_timer #(
    .W (CNT_W)
  ) u_rd_timer (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .limit_i   (tmr_limit),
    .hit_o     (tmr_hit)
  );

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    to_hit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (auto_q || (start && !busy_q)) begin
          state_d = ST_REQ_ID;
          launch  = 1'b1;
        end
      end
      ST_REQ_ID: begin
        if (!av_waitrequest) begin
          if (HAS_LAT) begin
            state_d = ST_LAT_ID;
          end else begin
            cap_id  = 1'b1;
            state_d = ST_REQ_TS;
          end
        end else if (tmr_hit) begin
          to_hit  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_LAT_ID: begin
        if (tmr_hit) begin
          cap_id  = 1'b1;
          state_d = ST_REQ_TS;
        end
      end
      ST_REQ_TS: begin
        if (!av_waitrequest) begin
          if (HAS_LAT) begin
            state_d = ST_LAT_TS;
          end else begin
            cap_ts  = 1'b1;
            state_d = ST_FIN;
          end
        end else if (tmr_hit) begin
          to_hit  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_LAT_TS: begin
        if (tmr_hit) begin
          cap_ts  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_d     = busy_q;
    done_d     = (state_q == ST_FIN);
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    if (launch) begin
      busy_d     = 1'b1;
      id_ok_d    = 1'b0;
      ts_ok_d    = 1'b0;
      timeout_d  = 1'b0;
      id_value_d = '0;
      ts_value_d = '0;
    end else if (done_q) begin
      busy_d = 1'b0;
    end
    if (cap_id) begin
      id_value_d = av_readdata;
      id_ok_d    = (av_readdata == EXPECTED_ID);
    end
    if (cap_ts) begin
      ts_value_d = av_readdata;
      ts_ok_d    = (av_readdata == EXPECTED_TS);
    end
    if (to_hit) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      auto_q     <= AUTO_START;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      auto_q     <= 1'b0;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign av_read    = in_req;
  assign av_address = (state_q == ST_REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy       = busy_q;
  assign done       = done_q;
  assign id_ok      = id_ok_q;
  assign ts_ok      = ts_ok_q;
  assign timeout    = timeout_q;
  assign id_value   = id_value_q;
  assign ts_value   = ts_value_q;

endmodule

// File: doc/system_0_sysid_checker.md
Name: system_0_sysid_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its readdata.
- After reset, or on a start request, reads word 0 (system ID) and then word 1 (build timestamp), and compares each against expected parameter values.
- Exposes captured values plus pass/fail/timeout status to the board-bring-up logic (LED/status register), so a stale FPGA image is flagged without software.

Parameters:
- EXPECTED_ID, 32'd0, value word 0 must return.
- EXPECTED_TS, 32'd1563397180, value word 1 must return.
- READ_LATENCY, 0, cycles from read acceptance to valid readdata (legal 0..3).
- TIMEOUT_CYCLES, 255, maximum wait cycles per read before abort (legal 1..65535).
- AUTO_START, 1, 1 = start one check automatically after reset release.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run a check
- av_address  out  1  slave word address (0 = ID, 1 = timestamp)
- av_read  out  1  read strobe
- av_waitrequest  in  1  slave stall; tie 0 for a zero-wait slave
- av_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check ends (pass, fail or timeout)
- id_ok  out  1  sticky: captured ID == EXPECTED_ID
- ts_ok  out  1  sticky: captured timestamp == EXPECTED_TS
- timeout  out  1  sticky: the last check aborted on timeout
- id_value  out  32  last captured ID
- ts_value  out  32  last captured timestamp

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0, every output is 0 and the FSM is in IDLE. Reset asserted mid-check aborts the check immediately with no done pulse.
- FSM states: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, FIN.
- IDLE -> REQ_ID on start=1, or on the first clock after reset release when AUTO_START=1.
- Entering REQ_ID clears id_ok, ts_ok, timeout, id_value and ts_value, and sets busy=1.
- REQ_x: drive av_read=1 with av_address=0 (ID) or 1 (TS). Hold av_read and av_address stable until av_waitrequest=0. That cycle is acceptance.
  - READ_LATENCY=0: capture av_readdata on the acceptance edge, then go to the next state (REQ_TS or FIN). Do not visit LAT_x.
  - READ_LATENCY>0: go to LAT_x with av_read=0, wait exactly READ_LATENCY cycles, capture av_readdata on the final edge, then advance.
- Compare is registered: id_ok/ts_ok update on the same edge as the capture into id_value/ts_value. Full 32-bit equality; no masking.
- Timeout: a per-read wait counter, width ceil(log2(TIMEOUT_CYCLES+1)), clears when entering REQ_x and increments on each cycle with av_waitrequest=1. When it reaches TIMEOUT_CYCLES, go to FIN with timeout=1 and av_read=0 on the next cycle. Remaining reads are skipped; values not yet read stay 0 and their ok flags stay 0.
- FIN: done=1 for exactly one cycle, busy=0 on the following cycle, then return to IDLE. Status outputs hold until the next check starts.
- Latency: zero-wait slave with READ_LATENCY=0 gives start -> done in 4 cycles (REQ_ID, REQ_TS, FIN, plus 1 registration cycle). Each waitrequest cycle or latency cycle adds 1.
- start while busy=1 (including in FIN) is ignored and not queued.
- start coincident with the AUTO_START launch produces a single check.
- av_read is never asserted outside REQ_x. av_address=0 whenever av_read=0.

Decomposition:
- Package system_0_sysid_pkg holds:
  - state enum sysid_chk_state_t (6 states);
  - constants SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1;
  - the width function for the timeout counter.
- One sub-module, system_0_sysid_rd_timer: a loadable down/up counter shared by the timeout count and the latency count.
  - Inputs: clear, enable, limit.
  - Output: hit.
  - The FSM, capture registers and compare logic stay in the top level.

Test Plan:
- AUTO_START=1, zero-wait slave returning 0 / 1563397180, latency 0 -> av_read high 2 cycles at addresses 0 then 1; done pulse on cycle 4; id_ok=1, ts_ok=1, ts_value=1563397180.
- Slave returns timestamp 1563397181 -> ts_ok=0, id_ok=1, ts_value=1563397181, timeout=0.
- READ_LATENCY=2, av_waitrequest high 3 cycles on each read -> av_read/av_address stable during stall; capture exactly 2 cycles after acceptance; done at cycle 14.
- av_waitrequest stuck high, TIMEOUT_CYCLES=8 -> av_read drops after 8 stalled cycles; timeout=1, id_ok=0, ts_value=0; one done pulse.
- start pulsed during busy, then again 3 cycles after done -> first ignored; second re-runs, clearing flags on entry to REQ_ID.
- reset_n low during LAT_TS -> all outputs 0 asynchronously, no done pulse; with AUTO_START=1 a fresh check begins after release.
